regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised successor to the CPU's 32x32 file register. Provides NUM_RD combinational
//  read ports with optional write-to-read bypass, an optional hardwired-zero register 0 and
//  a debug dump engine. The dump engine streams every register, one per handshake, to the
//  debug/UART unit. Sits in the ID stage: writes come from WB, reads feed the ID/EX latch.
// PARAMETERS
//  DATA_W    32  register width in bits
//  DEPTH     32  number of registers (power of two, >=2)
//  ADDR_W    $clog2(DEPTH)  address width (derived, localparam)
//  NUM_RD    2   number of pipeline read ports (1..4)
//  ZERO_REG  1   1: reg 0 always reads 0 and writes to it are dropped
//  BYPASS    1   1: a same-cycle write to a read address is forwarded to that read port
// PORTS
//  clk         in   1                clock; all state updates on posedge
//  rst         in   1                reset; asynchronous, active-low (0 = reset)
//  wr_en       in   1                write strobe from WB
//  wr_addr     in   ADDR_W           write address
//  wr_data     in   DATA_W           write data
//  rd_addr     in   NUM_RD*ADDR_W    packed read addresses; port i = [i*ADDR_W +: ADDR_W]
//  rd_data     out  NUM_RD*DATA_W    packed read data; port i = [i*DATA_W +: DATA_W]
//  dbg_start   in   1                request a full dump (sampled on posedge)
//  dbg_ready   in   1                consumer ready for the dump word
//  dbg_valid   out  1                dump word valid
//  dbg_addr    out  ADDR_W           address of the current dump word
//  dbg_data    out  DATA_W           current dump word
//  dbg_last    out  1                current word is register DEPTH-1
//  dbg_busy    out  1                dump engine not idle
//  dbg_done    out  1                one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low.
//  Reset: all registers 0, FSM IDLE. Registered outputs are 0: dbg_valid, dbg_addr,
//    dbg_data, dbg_last, dbg_busy, dbg_done. rd_data is 0 because the array is 0.
//  Write: on posedge with wr_en=1, regs[wr_addr] <= wr_data.
//    Dropped if ZERO_REG=1 and wr_addr=0.
//  Read (combinational, 0-cycle latency, per port):
//    ZERO_REG=1 and addr=0        -> 0
//    BYPASS=1, wr_en, wr_addr=addr -> wr_data
//    otherwise                     -> regs[addr]
//  Dump FSM states: IDLE, LOAD, SHOW, DONE.
//    IDLE: dbg_start=1 -> LOAD with ptr=0.
//    LOAD: dbg_data <= read(ptr) (same forwarding rules as the read ports);
//      dbg_addr <= ptr; dbg_last <= (ptr==DEPTH-1); dbg_valid <= 1; -> SHOW.
//    SHOW: dbg_data is held stable while dbg_valid && !dbg_ready, even if regs[ptr] is
//      written meanwhile. On dbg_ready: dbg_valid <= 0.
//      If dbg_last -> DONE, else ptr++ and -> LOAD.
//    DONE: dbg_done=1 for exactly one cycle, dbg_busy <= 0, -> IDLE.
//  Throughput is 1 word per 2 cycles at most. Full dump = 2*DEPTH+1 cycles with ready held 1.
//  dbg_busy = 1 in LOAD, SHOW and DONE.
//  dbg_start while busy is ignored, not queued. dbg_start in the DONE cycle is also ignored.
//  Pipeline reads and writes stay fully functional during a dump; no port is stalled.
//  ptr wraps naturally at ADDR_W bits; the FSM never increments past DEPTH-1.
//  Reset asserted mid-dump: FSM returns to IDLE immediately, dbg_valid drops
//    asynchronously, and the array clears.
//  dbg_ready while dbg_valid=0 has no effect.
// STRUCTURE
//  Shared package cpu_pkg: DATA_W/DEPTH defaults and the dbg FSM state enum
//    (localparam encoding: IDLE=0, LOAD=1, SHOW=2, DONE=3).
//  One sub-module: regfile_dump_fsm (states, ptr, dbg_* outputs). It drives a read address
//    into the array and receives the read data from the array.
//  The array, write logic and read/bypass muxes (generate loop over NUM_RD) live in the top.
// TESTING
//  1 Reset: hold rst=0 mid-activity; release; read all addrs on both ports -> all 0;
//    dbg_* all 0.
//  2 Write/read/bypass: write regs[5]=32'hDEAD_BEEF with rd_addr0=5 in the same cycle
//    -> rd_data0=DEADBEEF that cycle (BYPASS=1). Next cycle port1 addr 5 -> DEADBEEF.
//    With BYPASS=0 the same-cycle read -> 0.
//  3 Zero reg: write regs[0]=32'h1234 -> reads of addr 0 return 0 (ZERO_REG=1).
//    With ZERO_REG=0 they return 1234.
//  4 Dump, ready held 1: preload regs[i]=i+16; pulse dbg_start -> 32 words, addr 0..31,
//    data 16..47 (word 0 = 0 if ZERO_REG). dbg_last only on addr 31. dbg_done pulse at
//    cycle 65 after start.
//  5 Backpressure/hazard: dbg_ready=0 for 5 cycles on addr 3 while writing regs[3]=99
//    -> dbg_data is held at the old value. The following dump shows 99.
//    A second dbg_start while busy is ignored: exactly one dbg_done.
//  6 Reset mid-dump at addr 10 -> dbg_valid and dbg_busy go 0 asynchronously.
//    A new dbg_start restarts at addr 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cpu_pkg                                                      |
// | Description : Shared defaults for the CPU register file and the encoding   |
// |               of the register-dump state machine.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam int c_data_w_def = 32;
  localparam int c_depth_def  = 32;

  // Dump engine state encoding (kept as plain constants for legacy tools).
  typedef logic [1:0] dbg_state_t;
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_load = 2'd1;
  localparam logic [1:0] c_st_show = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_dump_fsm                                             |
// | Description : Streams every register of the file, one word per valid/ready |
// |               handshake, to the debug unit.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   clock, rising edge                                       |
// |   rst        in   asynchronous reset, active-low                           |
// |   i_start    in   request a full dump (ignored unless idle)                |
// |   i_ready    in   consumer accepts the current word                        |
// |   o_rd_addr  out  address looked up in the register array                  |
// |   i_rd_data  in   forwarded read data for o_rd_addr                        |
// |   o_valid    out  dump word valid                                          |
// |   o_addr     out  address of the dump word                                 |
// |   o_data     out  dump word                                                |
// |   o_last     out  dump word is the highest register                        |
// |   o_busy     out  engine not idle                                          |
// |   o_done     out  one-cycle pulse after the last word is accepted          |
// +----------------------------------------------------------------------------+
module regfile_dump_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W = c_data_w_def,
  parameter int DEPTH  = c_depth_def,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  dbg_state_t        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_busy;
  logic              r_done;

  // The pointer drives the array lookup directly; the word is captured in
  // LOAD, so later writes to the same register cannot disturb a held word.
  assign o_rd_addr = r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (i_start) begin
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_state <= c_st_load;
          end
        end
        c_st_load: begin
          r_data  <= i_rd_data;
          r_addr  <= r_ptr;
          r_last  <= (r_ptr == c_last_addr);
          r_valid <= 1'b1;
          r_state <= c_st_show;
        end
        c_st_show: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= c_st_done;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
              r_state <= c_st_load;
            end
          end
        end
        c_st_done: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_multiport                                            |
// | Description : Parametrised CPU register file with NUM_RD combinational     |
// |               read ports, optional write-to-read bypass, optional          |
// |               hardwired-zero register 0 and a debug dump engine.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   clock, rising edge                                       |
// |   rst        in   asynchronous reset, active-low                           |
// |   wr_en      in   write strobe from WB                                     |
// |   wr_addr    in   write address                                            |
// |   wr_data    in   write data                                               |
// |   rd_addr    in   packed read addresses, port i = [i*ADDR_W +: ADDR_W]     |
// |   rd_data    out  packed read data, port i = [i*DATA_W +: DATA_W]          |
// |   dbg_start  in   request a full register dump                             |
// |   dbg_ready  in   dump consumer ready                                      |
// |   dbg_valid  out  dump word valid                                          |
// |   dbg_addr   out  dump word address                                        |
// |   dbg_data   out  dump word                                                |
// |   dbg_last   out  dump word is register DEPTH-1                            |
// |   dbg_busy   out  dump engine not idle                                     |
// |   dbg_done   out  one-cycle pulse after the last word is accepted          |
// +----------------------------------------------------------------------------+
module regfile_multiport
  import cpu_pkg::*;
#(
  parameter int DATA_W   = c_data_w_def,
  parameter int DEPTH    = c_depth_def,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     dbg_start,
  input  logic                     dbg_ready,
  output logic                     dbg_valid,
  output logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     dbg_last,
  output logic                     dbg_busy,
  output logic                     dbg_done
);

  // One lookup per pipeline read port plus one for the dump engine, so the
  // dump sees exactly the same zero/bypass rules as the pipeline.
  localparam int c_num_lk = NUM_RD + 1;

  logic [DATA_W-1:0] r_regs    [DEPTH];
  logic [ADDR_W-1:0] w_lk_addr [c_num_lk];
  logic [DATA_W-1:0] w_lk_data [c_num_lk];
  logic [ADDR_W-1:0] w_dump_addr;
  logic              w_wr_ok;

  assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
    assign w_lk_addr[gi]                  = rd_addr[gi*ADDR_W +: ADDR_W];
    assign rd_data[gi*DATA_W +: DATA_W]   = w_lk_data[gi];
  end

  assign w_lk_addr[NUM_RD] = w_dump_addr;

  // The zero-register test precedes the bypass so a dropped write to
  // register 0 is never forwarded.
  for (genvar gi = 0; gi < c_num_lk; gi++) begin : g_lookup
    assign w_lk_data[gi] =
      ((ZERO_REG != 0) && (w_lk_addr[gi] == '0))               ? '0      :
      ((BYPASS != 0) && wr_en && (wr_addr == w_lk_addr[gi]))   ? wr_data :
                                                                 r_regs[w_lk_addr[gi]];
  end

  regfile_dump_fsm #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .i_start   (dbg_start),
    .i_ready   (dbg_ready),
    .o_rd_addr (w_dump_addr),
    .i_rd_data (w_lk_data[NUM_RD]),
    .o_valid   (dbg_valid),
    .o_addr    (dbg_addr),
    .o_data    (dbg_data),
    .o_last    (dbg_last),
    .o_busy    (dbg_busy),
    .o_done    (dbg_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_multiport                                         |
// | Description : Self-checking bench for regfile_multiport. A default         |
// |               instance (zero reg + bypass) and an alternate instance       |
// |               (neither) share the write/read stimulus.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_regfile_multiport;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic        dbg_start = 1'b0;
  logic        dbg_ready = 1'b0;

  logic [63:0] rd_data, a_rd_data;
  logic        dbg_valid, dbg_last, dbg_busy, dbg_done;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        a_dbg_valid, a_dbg_last, a_dbg_busy, a_dbg_done;
  logic [4:0]  a_dbg_addr;
  logic [31:0] a_dbg_data;

  always #5 clk = ~clk;

  regfile_multiport u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .dbg_start(dbg_start), .dbg_ready(dbg_ready),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_last(dbg_last), .dbg_busy(dbg_busy), .dbg_done(dbg_done)
  );

  regfile_multiport #(.ZERO_REG(0), .BYPASS(0)) u_alt (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(a_rd_data), .dbg_start(1'b0), .dbg_ready(1'b0),
    .dbg_valid(a_dbg_valid), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data),
    .dbg_last(a_dbg_last), .dbg_busy(a_dbg_busy), .dbg_done(a_dbg_done)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------- reference model
  // Register contents as they stand after each clock edge.
  logic [31:0] m_regs [DEPTH];   // register 0 stays zero
  logic [31:0] m_alt  [DEPTH];   // plain storage

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] = '0;
        m_alt[i]  = '0;
      end
    end else if (wr_en) begin
      m_alt[wr_addr] = wr_data;
      if (wr_addr != 0) m_regs[wr_addr] = wr_data;
    end
  end

  // With bypass a read returns the value the register holds after this edge.
  function automatic logic [31:0] exp_main(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_alt(input logic [4:0] a);
    return m_alt[a];
  endfunction

  task automatic check_reads();
    for (int p = 0; p < 2; p++) begin
      chk("rd_main", rd_data[p*32 +: 32], exp_main(rd_addr[p*ADDR_W +: ADDR_W]));
      chk("rd_alt", a_rd_data[p*32 +: 32], exp_alt(rd_addr[p*ADDR_W +: ADDR_W]));
    end
  endtask

  // Dump scoreboard: words must arrive in address order, each carrying the
  // register value current when it first became valid, held until accepted.
  int          exp_idx = 0;
  int          n_acc   = 0;
  int          n_done  = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] held = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (dbg_valid) begin
        if (!prev_valid) begin
          chk("dump_addr", dbg_addr, exp_idx);
          chk("dump_data", dbg_data, m_regs[exp_idx]);
          chk("dump_last", dbg_last, exp_idx == DEPTH - 1);
          held = dbg_data;
        end else begin
          chk("dump_hold", dbg_data, held);
        end
        if (dbg_ready) begin
          n_acc++;
          exp_idx = (exp_idx + 1) % DEPTH;
        end
      end
      if (dbg_done) begin
        n_done++;
        chk("done_words", n_acc, DEPTH);
        n_acc = 0;
      end
      prev_valid = dbg_valid;
    end
  end

  always @(negedge rst) begin
    exp_idx    = 0;
    n_acc      = 0;
    prev_valid = 1'b0;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (dbg_done) begin
        cyc = c;
        break;
      end
      step();
    end
    chk("done_seen", cyc != 0, 1'b1);
  endtask

  task automatic wait_word(input int a, input int bound);
    int found;
    found = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (dbg_valid && dbg_addr == a[4:0]) begin
        found = 1;
        break;
      end
      step();
    end
    chk("word_seen", found, 1);
  endtask

  task automatic pulse_start();
    step();
    dbg_start = 1'b1;
    step();
    dbg_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done_cyc;
    int nlast;
    int d0;

    // 1: reset in the middle of activity
    repeat (3) step();
    rst = 1'b1;
    dbg_ready = 1'b1;
    dbg_start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      dbg_start = 1'b0;
      wr_en   = 1'b1;
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
    end
    rst = 1'b0;
    wr_en = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {a[4:0], a[4:0]};
      @(negedge clk);
      chk("rst_rd_main", rd_data, 64'd0);
      chk("rst_rd_alt", a_rd_data, 64'd0);
      step();
    end
    chk("rst_dbg", {dbg_valid, dbg_addr, dbg_data, dbg_last, dbg_busy, dbg_done}, '0);
    chk("rst_dbg_alt", {a_dbg_valid, a_dbg_addr, a_dbg_data, a_dbg_last, a_dbg_busy, a_dbg_done}, '0);

    // 2: write/read/bypass
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("bypass_main", rd_data[31:0], 32'hDEAD_BEEF);
    chk("bypass_alt", a_rd_data[31:0], 32'd0);
    step();
    wr_en = 1'b0; rd_addr = {5'd5, 5'd0};
    @(negedge clk);
    chk("wr_p1_main", rd_data[63:32], 32'hDEAD_BEEF);
    chk("wr_p1_alt", a_rd_data[63:32], 32'hDEAD_BEEF);

    // 3: zero register
    step();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = '0;
    @(negedge clk);
    chk("zero_same_main", rd_data[31:0], 32'd0);
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("zero_main", rd_data, 64'd0);
    chk("zero_alt", a_rd_data, {32'h1234, 32'h1234});

    // 4: full dump with ready held high
    for (int i = 0; i < DEPTH; i++) begin
      step();
      wr_en = 1'b1; wr_addr = i[4:0]; wr_data = 32'(i + 16);
    end
    step();
    wr_en = 1'b0;
    dbg_ready = 1'b1;
    dbg_start = 1'b1;
    step();
    dbg_start = 1'b0;
    nlast = 0;
    done_cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (dbg_valid && dbg_last) nlast++;
      chk("busy_dump", dbg_busy, 1'b1);
      if (dbg_done) begin
        done_cyc = c;
        break;
      end
      step();
    end
    chk("done_cycle", done_cyc, 65);
    chk("last_count", nlast, 1);
    step();
    @(negedge clk);
    chk("idle_after_done", {dbg_busy, dbg_done, dbg_valid}, 3'b000);

    // 5: backpressure with a write to the held register
    pulse_start();
    wait_word(2, 50);
    step();
    dbg_ready = 1'b0;
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd99; dbg_start = 1'b1;
    d0 = n_done;
    @(negedge clk);
    chk("bp_word", {dbg_valid, dbg_addr}, {1'b1, 5'd3});
    step();
    wr_en = 1'b0; dbg_start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold", dbg_data, 32'd19);
      step();
    end
    dbg_ready = 1'b1;
    wait_done(200, done_cyc);
    repeat (10) step();
    chk("single_done", n_done - d0, 1);
    chk("bp_idle", dbg_busy, 1'b0);
    pulse_start();
    wait_word(3, 50);
    chk("new_dump_99", dbg_data, 32'd99);
    wait_done(200, done_cyc);

    // 6: reset in the middle of a dump
    pulse_start();
    wait_word(10, 50);
    #1 rst = 1'b0;
    #1;
    chk("async_valid", dbg_valid, 1'b0);
    chk("async_busy", dbg_busy, 1'b0);
    rd_addr = {5'd5, 5'd3};
    #1;
    chk("async_clear", rd_data, 64'd0);
    step();
    rst = 1'b1;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    chk("restart_addr", {dbg_valid, dbg_addr}, {1'b1, 5'd0});
    step();
    wait_done(200, done_cyc);

    // random traffic: writes, reads and dumps with random backpressure
    for (int c = 0; c < 1500; c++) begin
      step();
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_addr = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) rd_addr[4:0] = wr_addr;
      if ($urandom_range(0, 2) == 0) rd_addr[9:5] = wr_addr;
      dbg_ready = ($urandom_range(0, 3) != 0);
      dbg_start = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      check_reads();
    end
    step();
    wr_en = 1'b0; dbg_start = 1'b0; dbg_ready = 1'b1;
    repeat (100) step();
    @(negedge clk);
    chk("final_idle", dbg_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
